branch_ckpt_ctrl: RTL and testbench
===================================

BRANCH_CKPT_CTRL -- requirements
Module: branch_ckpt_ctrl

Interface
REQ-001 SHALL have parameter MAXBR, default 3, meaning the maximum number of outstanding unresolved branches; this equals the regfile checkpoint ring depth minus one.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port brIssue  input  1  dispatcher requests allocation of a checkpoint for a branch this cycle.
REQ-005 SHALL have port brResolveEn  input  1  branch unit reports a resolution this cycle.
REQ-006 SHALL have port brMispredict  input  1  qualifies brResolveEn; 1 = mispredicted, 0 = correctly predicted.
REQ-007 SHALL have port brResolveId  input  2  checkpoint slot ID of the branch being resolved.
REQ-008 SHALL have port brIssueAck  output  1  allocation granted this cycle.
REQ-009 SHALL have port brIssueId  output  2  slot ID assigned to the granted branch (the current tail+1, mod 4).
REQ-010 SHALL have port branchDeeper  output  1  to regfile: advance the checkpoint tail.
REQ-011 SHALL have port bFreeEn  output  1  to regfile: retire the oldest checkpoint (head+1).
REQ-012 SHALL have port misTaken  output  1  to regfile and ROB: roll back to head.
REQ-013 SHALL have port brStall  output  1  dispatcher must not issue branches.
REQ-014 SHALL have port brCurMask  output  3  thermometer mask of outstanding branches.
REQ-015 SHALL have port brErr  output  1  sticky protocol-violation flag.

Function
REQ-016 SHALL keep the following state: head[1:0], tail[1:0], count[1:0] (0..MAXBR), FSM {RUN, FLUSH}, and brErr.
REQ-017 SHALL define resolveOk as brResolveEn & state==RUN & count!=0 & brResolveId==nxtHead, where nxtHead = head+1 mod 4.
REQ-018 SHALL drive misTaken = resolveOk & brMispredict, combinationally in the same cycle.
REQ-019 SHALL drive bFreeEn = resolveOk & ~brMispredict, combinationally.
REQ-020 SHALL drive brIssueAck = branchDeeper = brIssue & ~brStall & ~misTaken, combinationally.
REQ-021 SHALL drive brStall = (count==MAXBR & ~bFreeEn) | state==FLUSH; a free in the same cycle frees a slot for an issue in that cycle.
REQ-022 SHALL drive brIssueId = tail+1 mod 4.
REQ-023 SHALL update as follows on an issue without a free: tail <= tail+1 and count <= count+1.
REQ-024 SHALL update as follows on a free without an issue: head <= head+1 and count <= count-1.
REQ-025 SHALL update as follows on an issue and a free in the same cycle: head and tail both advance, and count is unchanged.
REQ-026 SHALL update as follows on misTaken: tail <= head, count <= 0, state <= FLUSH; any simultaneous brIssue is dropped (brIssueAck=0) and the dispatcher retries.
REQ-027 SHALL leave FLUSH for RUN unconditionally after exactly one cycle; during FLUSH all resolves are ignored and no brErr is raised.
REQ-028 SHALL drive brCurMask from count: 0 -> 000, 1 -> 001, 2 -> 011, 3 -> 111.
REQ-029 SHALL set brErr (held until reset) when brResolveEn is asserted in RUN with count==0 or brResolveId!=nxtHead; such a resolve has no other effect.
REQ-030 SHALL wrap head and tail modulo 4 (3 -> 0).
REQ-031 SHALL never let count exceed MAXBR or underflow below 0.

Reset
REQ-032 SHALL, on rst, set head=0, tail=0, count=0, state=RUN, brErr=0; with inputs idle this gives brCurMask=000, brStall=0, and branchDeeper, bFreeEn, misTaken and brIssueAck all 0.
REQ-033 SHALL give rst priority over every simultaneous issue or resolve; all combinational outputs are don't-care during rst, but state is cleared at the edge.

Verification
REQ-034 SHALL verify fill: three back-to-back brIssue from reset -> brIssueId 1,2,3; brCurMask 001,011,111; brStall=1 in cycle 4; a fourth brIssue gives ack=0.
REQ-035 SHALL verify full with free: count=3 with resolve id=1 (correct) and brIssue in the same cycle -> bFreeEn=1, ack=1, brIssueId=0 (wrap); next cycle head=1, tail=0, count=3.
REQ-036 SHALL verify mispredict: count=2 with resolve id=head+1 and mispredict=1, plus brIssue -> misTaken=1, ack=0; next cycle brStall=1 and mask=000; the cycle after that, state is RUN and brStall=0.
REQ-037 SHALL verify out-of-order resolve: count=2, head=0, resolve id=2 -> no bFreeEn or misTaken, brErr=1 and stays 1 until rst.
REQ-038 SHALL verify reset mid-operation: count=3, assert rst with brIssue=1 -> next cycle count=0, head=tail=0, brErr=0, mask=000.

Source files
------------

// File: rtl/branch_ckpt_ctrl_if.sv
// rtl/branch_ckpt_ctrl_if.sv - dispatcher/branch-unit/regfile handshake bundle for the branch checkpoint controller
//
// Signals (direction as seen by the controller, i.e. the slave modport):
//   brIssue       in   dispatcher requests a checkpoint for a branch this cycle
//   brResolveEn   in   branch unit reports a resolution this cycle
//   brMispredict  in   qualifies brResolveEn: 1 = mispredicted, 0 = correct
//   brResolveId   in   checkpoint slot of the branch being resolved
//   brIssueAck    out  allocation granted this cycle
//   brIssueId     out  slot assigned to the granted branch
//   branchDeeper  out  regfile: advance the checkpoint tail
//   bFreeEn       out  regfile: retire the oldest checkpoint
//   misTaken      out  regfile and ROB: roll back to head
//   brStall       out  dispatcher must not issue branches
//   brCurMask     out  thermometer mask of outstanding branches
//   brErr         out  sticky protocol-violation flag
interface branch_ckpt_ctrl_if;
  logic       brIssue;
  logic       brResolveEn;
  logic       brMispredict;
  logic [1:0] brResolveId;
  logic       brIssueAck;
  logic [1:0] brIssueId;
  logic       branchDeeper;
  logic       bFreeEn;
  logic       misTaken;
  logic       brStall;
  logic [2:0] brCurMask;
  logic       brErr;

  modport master (
    output brIssue, brResolveEn, brMispredict, brResolveId,
    input  brIssueAck, brIssueId, branchDeeper, bFreeEn, misTaken,
           brStall, brCurMask, brErr
  );

  modport slave (
    input  brIssue, brResolveEn, brMispredict, brResolveId,
    output brIssueAck, brIssueId, branchDeeper, bFreeEn, misTaken,
           brStall, brCurMask, brErr
  );
endinterface

// File: rtl/branch_ckpt_ctrl.sv
// rtl/branch_ckpt_ctrl.sv - allocation, retirement and rollback control for the regfile branch checkpoint ring
//
// Ports:
//   clk  in     system clock, all state updates on the rising edge
//   rst  in     synchronous active-high reset
//   bif  slave  branch_ckpt_ctrl_if bundle (issue request/ack, resolve,
//               regfile checkpoint controls, stall, mask, sticky error)
//
// The ring has four slots. head names the last retired checkpoint (the
// architectural rollback point); tail names the newest allocated one. The
// oldest outstanding branch therefore lives in slot head+1, and a new branch
// is given slot tail+1. MAXBR outstanding branches leave one slot spare so
// head never collides with an allocated checkpoint.
module branch_ckpt_ctrl #(
  parameter int MAXBR = 3
) (
  input  logic                clk,
  input  logic                rst,
  branch_ckpt_ctrl_if.slave   bif
);

  if (MAXBR < 1 || MAXBR > 3) begin : g_bad_maxbr
    $error("branch_ckpt_ctrl: MAXBR must be in 1..3");
  end

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  localparam logic [1:0] MAXCNT = 2'(MAXBR);

  logic [0:0] state;
  logic [1:0] head;
  logic [1:0] tail;
  logic [1:0] count;
  logic       err_q;

  logic [1:0] nxt_head;
  logic [1:0] nxt_tail;
  logic       resolve_run;
  logic       resolve_ok;
  logic       mis_taken;
  logic       free_en;
  logic       stall;
  logic       issue_go;
  logic       proto_err;
  logic [2:0] cur_mask;

  assign nxt_head = head + 2'd1;
  assign nxt_tail = tail + 2'd1;

  // Resolves only count while running; the FLUSH cycle swallows any late
  // resolve from the squashed path without flagging it.
  assign resolve_run = bif.brResolveEn & (state == RUN);
  assign resolve_ok  = resolve_run & (count != 2'd0) & (bif.brResolveId == nxt_head);
  assign proto_err   = resolve_run & ~resolve_ok;

  assign mis_taken = resolve_ok & bif.brMispredict;
  assign free_en   = resolve_ok & ~bif.brMispredict;

  // A retirement in the same cycle opens the slot the issue needs.
  assign stall    = ((count == MAXCNT) & ~free_en) | (state == FLUSH);
  assign issue_go = bif.brIssue & ~stall & ~mis_taken;

  always_comb begin
    cur_mask = 3'b000;
    case (count)
      2'd0:    cur_mask = 3'b000;
      2'd1:    cur_mask = 3'b001;
      2'd2:    cur_mask = 3'b011;
      default: cur_mask = 3'b111;
    endcase
  end

  assign bif.misTaken     = mis_taken;
  assign bif.bFreeEn      = free_en;
  assign bif.brStall      = stall;
  assign bif.brIssueAck   = issue_go;
  assign bif.branchDeeper = issue_go;
  assign bif.brIssueId    = nxt_tail;
  assign bif.brCurMask    = cur_mask;
  assign bif.brErr        = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      head  <= 2'd0;
      tail  <= 2'd0;
      count <= 2'd0;
      err_q <= 1'b0;
    end else begin
      if (proto_err) begin
        err_q <= 1'b1;
      end

      if (mis_taken) begin
        // Discard every younger checkpoint; head stays as the restore point.
        tail  <= head;
        count <= 2'd0;
        state <= FLUSH;
      end else begin
        state <= RUN;
        if (issue_go) begin
          tail <= nxt_tail;
        end
        if (free_en) begin
          head <= nxt_head;
        end
        case ({issue_go, free_en})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_ckpt_ctrl.sv
// tb/tb_branch_ckpt_ctrl.sv - scoreboard bench for branch_ckpt_ctrl with a queue-based reference model
module tb_branch_ckpt_ctrl;

  localparam int MAXBR = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  branch_ckpt_ctrl_if bif ();

  branch_ckpt_ctrl #(.MAXBR(MAXBR)) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif)
  );

  typedef struct {
    bit         skip;
    int         cyc;
    logic       ack;
    logic [1:0] id;
    logic       free;
    logic       mis;
    logic       stall;
    logic [2:0] mask;
    logic       err;
  } exp_t;

  exp_t exp_q[$];

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  // Reference model: outstanding branches are the slot numbers in issue order.
  int out_q[$];
  int retired_id = 0;
  int last_id    = 0;
  bit flushing   = 0;
  bit err_m      = 0;

  task automatic chk(input string name, input int c, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, c, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit iss, input bit ren, input bit mis, input logic [1:0] rid);
    exp_t e;
    int   cnt;
    bit   ok;
    @(posedge clk);
    #1;
    cyc++;
    rst              = r;
    bif.brIssue      = iss;
    bif.brResolveEn  = ren;
    bif.brMispredict = mis;
    bif.brResolveId  = rid;

    e.skip = r;
    e.cyc  = cyc;
    if (r) begin
      out_q.delete();
      retired_id = 0;
      last_id    = 0;
      flushing   = 0;
      err_m      = 0;
      e.ack = 0; e.id = 0; e.free = 0; e.mis = 0; e.stall = 0; e.mask = 0; e.err = 0;
    end else begin
      cnt     = out_q.size();
      ok      = ren && !flushing && cnt > 0 && int'(rid) == out_q[0];
      e.mis   = ok && mis;
      e.free  = ok && !mis;
      e.stall = flushing || (cnt == MAXBR && !e.free);
      e.ack   = iss && !e.stall && !e.mis;
      e.id    = 2'((last_id + 1) % 4);
      e.mask  = 3'((1 << cnt) - 1);
      e.err   = err_m;

      if (ren && !flushing && !ok) err_m = 1;
      if (e.mis) begin
        out_q.delete();
        last_id  = retired_id;
        flushing = 1;
      end else begin
        flushing = 0;
        if (e.free) retired_id = out_q.pop_front();
        if (e.ack) begin
          out_q.push_back(int'(e.id));
          last_id = int'(e.id);
        end
      end
    end
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (!e.skip) begin
          chk("brIssueAck",   e.cyc, 8'(bif.brIssueAck),   8'(e.ack));
          chk("branchDeeper", e.cyc, 8'(bif.branchDeeper), 8'(e.ack));
          chk("brIssueId",    e.cyc, 8'(bif.brIssueId),    8'(e.id));
          chk("bFreeEn",      e.cyc, 8'(bif.bFreeEn),      8'(e.free));
          chk("misTaken",     e.cyc, 8'(bif.misTaken),     8'(e.mis));
          chk("brStall",      e.cyc, 8'(bif.brStall),      8'(e.stall));
          chk("brCurMask",    e.cyc, 8'(bif.brCurMask),    8'(e.mask));
          chk("brErr",        e.cyc, 8'(bif.brErr),        8'(e.err));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit         r, iss, ren, mis;
    logic [1:0] rid;
    bif.brIssue      = 0;
    bif.brResolveEn  = 0;
    bif.brMispredict = 0;
    bif.brResolveId  = 0;

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);                 // reset state, idle outputs

    // fill: ids 1,2,3 then stall and refused fourth issue
    repeat (3) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    // full with same-cycle free: issue wraps to slot 0
    step(0, 1, 1, 0, 2'd1);
    step(0, 0, 0, 0, 0);
    // retire slot 2 -> count 2, then mispredict slot 3 with an issue
    step(0, 0, 1, 0, 2'd2);
    step(0, 1, 1, 1, 2'd3);
    step(0, 1, 1, 0, 2'd0);              // FLUSH: stall, resolve ignored, no error
    step(0, 1, 0, 0, 0);                 // back in RUN, reissue into slot 3

    // out-of-order resolve from a clean reset
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 2'd2);
    repeat (3) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 2'd1);              // legal resolve after the error still works

    // reset mid-operation with an issue pending
    step(1, 0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);

    // randomized traffic, resolves biased toward the oldest branch
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 79) == 0);
      iss = ($urandom_range(0, 9) < 6);
      ren = ($urandom_range(0, 9) < 5);
      mis = ($urandom_range(0, 9) < 2);
      if (out_q.size() > 0 && $urandom_range(0, 5) != 0) rid = 2'(out_q[0]);
      else rid = 2'($urandom_range(0, 3));
      step(r, iss, ren, mis, rid);
    end

    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL drain got=%0d pending expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
